// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Build option MULDIV_EARLY_OUT_EN (see muldiv_unit) does not change this package.
package muldiv_pkg;

  localparam int MULDIV_W = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_signed_a(input muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issuing datapath (master) and the
// multiply/divide unit (slave).
interface muldiv_if #(parameter int WIDTH = muldiv_pkg::MULDIV_W);
  import muldiv_pkg::*;

  logic             start;
  logic             kill;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, kill, funct3, op_a, op_b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, funct3, op_a, op_b,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Operates purely on unsigned magnitudes.
module muldiv_step #(
  parameter int WIDTH = muldiv_pkg::MULDIV_W
) (
  input  logic [WIDTH-1:0] partial,
  input  logic [WIDTH-1:0] operand,
  input  logic             in_bit,
  input  logic             div_mode,
  output logic [WIDTH-1:0] next_partial,
  output logic             out_bit
);
  import muldiv_pkg::*;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // diff[WIDTH] is the borrow: set exactly when the shifted remainder is below the divisor.
  always_comb begin
    sum     = {1'b0, partial} + (in_bit ? {1'b0, operand} : '0);
    shifted = {partial, in_bit};
    diff    = shifted - {1'b0, operand};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        next_partial = diff[WIDTH-1:0];
        out_bit      = 1'b1;
      end else begin
        next_partial = shifted[WIDTH-1:0];
        out_bit      = 1'b0;
      end
    end else begin
      next_partial = sum[WIDTH:1];
      out_bit      = sum[0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, stalling via busy.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand muls and divide-by-zero in one cycle.
module muldiv_unit #(
  parameter int WIDTH = muldiv_pkg::MULDIV_W
) (
  input  logic    clk,
  input  logic    reset_n,
  muldiv_if.slave bus
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(WIDTH) + 1;

  muldiv_state_e    state;
  muldiv_op_e       op;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [CW-1:0]    count;
  logic             neg_res;
  logic             div_zero;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  muldiv_op_e       new_op;
  logic             new_sa;
  logic             new_sb;
  logic [WIDTH-1:0] new_mag_a;
  logic [WIDTH-1:0] new_mag_b;
  logic             new_neg;

  always_comb begin
    new_op    = muldiv_op_e'(bus.funct3);
    new_sa    = op_signed_a(new_op) & bus.op_a[WIDTH-1];
    new_sb    = op_signed_b(new_op) & bus.op_b[WIDTH-1];
    new_mag_a = new_sa ? -bus.op_a : bus.op_a;
    new_mag_b = new_sb ? -bus.op_b : bus.op_b;
    new_neg   = (new_op inside {OP_REM, OP_REMU}) ? new_sa : (new_sa ^ new_sb);
    accept    = bus.start & ~bus.kill & ((state == IDLE) | (state == DONE));
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic             early;
  logic [WIDTH-1:0] early_value;

  always_comb begin
    early       = op_is_div(new_op) ? (bus.op_b == '0)
                                    : ((bus.op_a == '0) | (bus.op_b == '0));
    early_value = '0;
    if (op_is_div(new_op))
      early_value = (new_op inside {OP_DIV, OP_DIVU}) ? '1 : bus.op_a;
  end
`endif

  logic [WIDTH-1:0] step_partial;
  logic             step_bit;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .partial      (hi),
    .operand      (mag_b),
    .in_bit       (op_is_div(op) ? lo[WIDTH-1] : lo[0]),
    .div_mode     (op_is_div(op)),
    .next_partial (step_partial),
    .out_bit      (step_bit)
  );

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   rem_src;
  logic [WIDTH-1:0]   fix_value;

  // A zero divisor leaves garbage in hi/lo, so quotient and remainder are forced here.
  always_comb begin
    prod_fixed = neg_res ? -{hi, lo} : {hi, lo};
    rem_src    = div_zero ? mag_a : hi;
    case (op)
      OP_MUL:                       fix_value = prod_fixed[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_value = prod_fixed[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_value = div_zero ? '1 : (neg_res ? -lo : lo);
      default:                      fix_value = neg_res ? -rem_src : rem_src;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op       <= OP_MUL;
      hi       <= '0;
      lo       <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      count    <= '0;
      neg_res  <= 1'b0;
      div_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op       <= new_op;
            mag_a    <= new_mag_a;
            mag_b    <= new_mag_b;
            neg_res  <= new_neg;
            div_zero <= (bus.op_b == '0);
            hi       <= '0;
            lo       <= new_mag_a;
            count    <= CW'(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
            if (early) begin
              state    <= DONE;
              done_q   <= 1'b1;
              result_q <= early_value;
            end else begin
              state  <= CALC;
              busy_q <= 1'b1;
            end
`else
            state  <= CALC;
            busy_q <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (bus.kill) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            hi    <= step_partial;
            lo    <= op_is_div(op) ? {lo[WIDTH-2:0], step_bit} : {step_bit, lo[WIDTH-1:1]};
            count <= count - CW'(1);
            if (count == CW'(1))
              state <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (bus.kill) begin
            state <= IDLE;
          end else begin
            state    <= DONE;
            done_q   <= 1'b1;
            result_q <= fix_value;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; results are scoreboarded on done.
// Latency expectations follow MULDIV_EARLY_OUT_EN when it is defined for the build.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = MULDIV_W;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  task automatic check_output(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input muldiv_op_e f, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] expected,
                                input string tag, input bit expect_done);
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.start  = 1'b1;
    if (expect_done) begin
      exp_q.push_back(expected);
      tag_q.push_back(tag);
    end
  endtask

  // Counts cycles from the accept edge until done; optionally pokes start while busy.
  task automatic wait_done(input int poke_cycle, output int cycles, output int busy_cycles);
    cycles      = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == poke_cycle) begin
        bus.start  = 1'b1;
        bus.funct3 = OP_MULHU;
        bus.op_a   = 32'h55;
        bus.op_b   = 32'h55;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cycles++;
    end while (!bus.done && cycles < 100);
    if (!bus.done) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL timeout: no done within %0d cycles", cycles);
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL spurious_done: observed result 0x%h with no request outstanding", bus.result);
      end else begin
        check_output(tag_q.pop_front(), bus.result, exp_q.pop_front());
      end
    end
  end

  initial begin
    int           cyc;
    int           bcyc;
    int           pulses;
    logic [W-1:0] prev;

    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = '0;
    bus.op_b   = '0;

    repeat (3) @(negedge clk);
    check_output("reset_busy",   W'(bus.busy), '0);
    check_output("reset_done",   W'(bus.done), '0);
    check_output("reset_result", bus.result,   '0);
    reset_n = 1'b1;
    @(negedge clk);

    apply_stimulus(OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_x_m3", 1'b1);
    wait_done(0, cyc, bcyc);
    check_output("mul_latency",     W'(cyc),  W'(34));
    check_output("mul_busy_cycles", W'(bcyc), W'(33));
    @(negedge clk);
    check_output("done_single_pulse", W'(bus.done), '0);
    check_output("idle_not_busy",     W'(bus.busy), '0);

    apply_stimulus(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1", 1'b1);
    wait_done(0, cyc, bcyc);
    apply_stimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max", 1'b1);
    wait_done(0, cyc, bcyc);
    check_output("back_to_back_latency", W'(cyc), W'(34));
    apply_stimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max_max", 1'b1);
    wait_done(0, cyc, bcyc);
    apply_stimulus(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2", 1'b1);
    wait_done(0, cyc, bcyc);
    apply_stimulus(OP_REM, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2", 1'b1);
    wait_done(0, cyc, bcyc);
    apply_stimulus(OP_DIVU, 32'h8000_0000, 32'h0000_0003, 32'h2AAA_AAAA, "divu_min_3", 1'b1);
    wait_done(0, cyc, bcyc);
    apply_stimulus(OP_DIV, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "div_by_zero", 1'b1);
    wait_done(0, cyc, bcyc);
    apply_stimulus(OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu_by_zero", 1'b1);
    wait_done(0, cyc, bcyc);
    apply_stimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow", 1'b1);
    wait_done(0, cyc, bcyc);
    apply_stimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_overflow", 1'b1);
    wait_done(0, cyc, bcyc);

    @(negedge clk);
    apply_stimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, "divu_start_ignored", 1'b1);
    wait_done(5, cyc, bcyc);
    check_output("start_while_busy_latency", W'(cyc), W'(34));

    prev = 32'd14;
    apply_stimulus(OP_MUL, 32'd3, 32'd5, '0, "mul_killed", 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check_output("kill_busy_drop", W'(bus.busy), '0);
    check_output("kill_result_kept", bus.result, prev);
    count_done(40, pulses);
    check_output("kill_no_done", W'(pulses), '0);

    bus.funct3 = OP_MUL;
    bus.op_a   = 32'd2;
    bus.op_b   = 32'd3;
    bus.start  = 1'b1;
    bus.kill   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    check_output("kill_beats_start_busy", W'(bus.busy), '0);
    count_done(40, pulses);
    check_output("kill_beats_start_no_done", W'(pulses), '0);

    apply_stimulus(OP_DIV, 32'd1000, 32'd3, '0, "div_reset_mid", 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_output("async_reset_busy",   W'(bus.busy), '0);
    check_output("async_reset_done",   W'(bus.done), '0);
    check_output("async_reset_result", bus.result,   '0);
    @(negedge clk);
    reset_n = 1'b1;
    count_done(40, pulses);
    check_output("reset_no_done", W'(pulses), '0);

    apply_stimulus(OP_MUL, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, "mul_zero", 1'b1);
    wait_done(0, cyc, bcyc);
`ifdef MULDIV_EARLY_OUT_EN
    check_output("early_out_latency", W'(cyc),  W'(1));
    check_output("early_out_busy",    W'(bcyc), W'(0));
`else
    check_output("zero_mul_latency", W'(cyc),  W'(34));
    check_output("zero_mul_busy",    W'(bcyc), W'(33));
`endif

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
